r2a03_ext_bus_mux: RTL and testbench

- Parametrised external-bus sequencer between the 2A03 core's parallel bus and the narrow Tiny Tapeout pin set.
- Time-multiplexes address slices onto the dedicated outputs and moves data over the bidirectional pins, with turnaround, wait-state and timeout support.
- Sits inside tt_um_fjpolo_r2a03, between the CPU/DMA bus master and the ui/uo/uio pins.

---
 rtl/r2a03_pkg.sv | 19 +
 rtl/r2a03_ext_bus_mux.sv | 244 ++++++++++++++++++++++++
 tb/tb_r2a03_ext_bus_mux.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/r2a03_pkg.sv
// Shared definitions for the 2A03 external-bus sequencer: FSM state
// encoding, slice-index width and the ceil-divide used to size slices.
package r2a03_pkg;

    localparam int SLICE_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_TURN,
        ST_DATA,
        ST_DONE
    } bus_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/r2a03_ext_bus_mux.sv
// External-bus sequencer: serialises the core's parallel address onto a
// narrow pin slice, then moves data over the bidirectional pins with
// optional turnaround, wait states and wait timeout.
module r2a03_ext_bus_mux
    import r2a03_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int PIN_W    = 8,
    parameter int TURN_CYC = 1,
    parameter int WAIT_MAX = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ack,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic [PIN_W-1:0]       pin_out,
    output logic                   ale,
    output logic [SLICE_IDX_W-1:0] slice_idx,
    output logic                   rd_n,
    output logic                   wr_n,
    input  logic [PIN_W-1:0]       pin_io_in,
    output logic [PIN_W-1:0]       pin_io_out,
    output logic [PIN_W-1:0]       pin_io_oe,
    input  logic                   ext_wait
);

    localparam int ASL   = ceil_div(ADDR_W, PIN_W);
    localparam int DSL   = ceil_div(DATA_W, PIN_W);
    localparam int AW_P  = ASL * PIN_W;
    localparam int DW_P  = DSL * PIN_W;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] ASL_LAST  = CNT_W'(ASL - 1);
    localparam logic [CNT_W-1:0] DSL_LAST  = CNT_W'(DSL - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(WAIT_MAX);
    localparam logic [DW_P-1:0]  SLICE_MASK = DW_P'({PIN_W{1'b1}});

    bus_state_t             r_state;
    bus_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_wait;
    logic [CNT_W-1:0]       w_wait_nxt;
    logic                   r_we;
    logic                   w_we_nxt;
    logic [AW_P-1:0]        r_addr;
    logic [AW_P-1:0]        w_addr_nxt;
    logic [DW_P-1:0]        r_wdata;
    logic [DW_P-1:0]        w_wdata_nxt;
    logic [DW_P-1:0]        r_rbuf;
    logic [DW_P-1:0]        w_rbuf_nxt;
    logic                   w_timeout;
    int                     w_sh_cur;
    int                     w_sh_nxt;

    logic                   r_ack,   w_ack_nxt;
    logic                   r_err,   w_err_nxt;
    logic [DATA_W-1:0]      r_rdata, w_rdata_nxt;
    logic [PIN_W-1:0]       r_pout,  w_pout_nxt;
    logic                   r_ale,   w_ale_nxt;
    logic [SLICE_IDX_W-1:0] r_sidx,  w_sidx_nxt;
    logic                   r_rd_n,  w_rd_n_nxt;
    logic                   r_wr_n,  w_wr_n_nxt;
    logic [PIN_W-1:0]       r_pio,   w_pio_nxt;
    logic [PIN_W-1:0]       r_oe,    w_oe_nxt;

    // Next-state, slice counters, wait counter and read-data assembly
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rbuf_nxt  = r_rbuf;
        w_rdata_nxt = r_rdata;
        w_timeout   = 1'b0;
        w_sh_cur    = int'(r_cnt) * PIN_W;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_state_nxt = ST_ADDR;
                    w_cnt_nxt   = '0;
                    w_wait_nxt  = '0;
                    w_we_nxt    = we;
                    w_addr_nxt  = '0;
                    w_addr_nxt[ADDR_W-1:0] = addr;
                    w_wdata_nxt = '0;
                    w_wdata_nxt[DATA_W-1:0] = wdata;
                end
            end
            ST_ADDR: begin
                if (r_cnt == ASL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (TURN_CYC > 0) ? ST_TURN : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_TURN: begin
                if (r_cnt == TURN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                // Timeout is checked on the registered count so the full
                // WAIT_MAX wait cycles are spent before giving up.
                if ((WAIT_MAX != 0) && (r_wait == WAIT_LIM)) begin
                    w_state_nxt = ST_DONE;
                    w_timeout   = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = '0;
                    end
                end else if (ext_wait) begin
                    w_wait_nxt = r_wait + CNT_ONE;
                end else begin
                    if (!r_we) begin
                        w_rbuf_nxt = (r_rbuf & ~(SLICE_MASK << w_sh_cur)) |
                                     (DW_P'(pin_io_in) << w_sh_cur);
                    end
                    if (r_cnt == DSL_LAST) begin
                        w_state_nxt = ST_DONE;
                        if (!r_we) begin
                            w_rdata_nxt = w_rbuf_nxt[DATA_W-1:0];
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pin-side outputs decoded from the next state so the registered
    // outputs line up with the state they describe
    always_comb begin
        w_sh_nxt   = int'(w_cnt_nxt) * PIN_W;
        w_ack_nxt  = 1'b0;
        w_err_nxt  = w_timeout;
        w_pout_nxt = '0;
        w_ale_nxt  = 1'b0;
        w_sidx_nxt = '0;
        w_rd_n_nxt = 1'b1;
        w_wr_n_nxt = 1'b1;
        w_pio_nxt  = '0;
        w_oe_nxt   = '0;

        case (w_state_nxt)
            ST_ADDR: begin
                w_pout_nxt = PIN_W'(w_addr_nxt >> w_sh_nxt);
                w_ale_nxt  = 1'b1;
                w_sidx_nxt = w_cnt_nxt[SLICE_IDX_W-1:0];
            end
            ST_DATA: begin
                w_sidx_nxt = w_cnt_nxt[SLICE_IDX_W-1:0];
                if (w_we_nxt) begin
                    w_pio_nxt  = PIN_W'(w_wdata_nxt >> w_sh_nxt);
                    w_oe_nxt   = '1;
                    w_wr_n_nxt = 1'b0;
                end else begin
                    w_rd_n_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                w_ack_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Control state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_pout  <= '0;
            r_ale   <= 1'b0;
            r_sidx  <= '0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_pio   <= '0;
            r_oe    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wait  <= w_wait_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_pout  <= w_pout_nxt;
            r_ale   <= w_ale_nxt;
            r_sidx  <= w_sidx_nxt;
            r_rd_n  <= w_rd_n_nxt;
            r_wr_n  <= w_wr_n_nxt;
            r_pio   <= w_pio_nxt;
            r_oe    <= w_oe_nxt;
        end
    end

    // Latched transaction fields and read assembly buffer
    always_ff @(posedge clk) begin
        r_we    <= w_we_nxt;
        r_addr  <= w_addr_nxt;
        r_wdata <= w_wdata_nxt;
        r_rbuf  <= w_rbuf_nxt;
    end

    assign ack        = r_ack;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign pin_out    = r_pout;
    assign ale        = r_ale;
    assign slice_idx  = r_sidx;
    assign rd_n       = r_rd_n;
    assign wr_n       = r_wr_n;
    assign pin_io_out = r_pio;
    assign pin_io_oe  = r_oe;

endmodule

// File: tb/tb_r2a03_ext_bus_mux.sv
// Directed bench for r2a03_ext_bus_mux: default, timeout-enabled and
// odd-width instances, with a queue of expected completions.
module tb_r2a03_ext_bus_mux;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [7:0] rdata;
        logic [7:0] pin_out;
        logic       ale;
        logic [3:0] sidx;
        logic       rd_n;
        logic       wr_n;
        logic [7:0] pio;
        logic [7:0] oe;
    } obs_t;

    typedef struct {
        logic       err;
        logic [7:0] rd;
        logic       chk_rd;
        int         lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_t = 1'b0, req_o = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  pin_io_in = '0;
    logic        ext_wait = 1'b0;

    logic       ack_a, err_a, ale_a, rdn_a, wrn_a;
    logic [7:0] rdata_a, pout_a, pio_a, oe_a;
    logic [3:0] sidx_a;
    logic       ack_t, err_t, ale_t, rdn_t, wrn_t;
    logic [7:0] rdata_t, pout_t, pio_t, oe_t;
    logic [3:0] sidx_t;
    logic       ack_o, err_o, ale_o, rdn_o, wrn_o;
    logic [7:0] rdata_o;
    logic [3:0] pout_o, pio_o, oe_o, sidx_o;

    int   total = 0;
    int   bad = 0;
    sb_t  sb[$];
    obs_t tr[0:47];
    logic [7:0] rseq[0:3];
    int   rdlow, wrlow;
    logic [7:0] oe_or;
    obs_t rst_obs;

    always #5 clk = ~clk;

    r2a03_ext_bus_mux u_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_a), .err(err_a), .rdata(rdata_a), .pin_out(pout_a), .ale(ale_a),
        .slice_idx(sidx_a), .rd_n(rdn_a), .wr_n(wrn_a), .pin_io_in(pin_io_in),
        .pin_io_out(pio_a), .pin_io_oe(oe_a), .ext_wait(ext_wait)
    );

    r2a03_ext_bus_mux #(.WAIT_MAX(4)) u_t (
        .clk(clk), .rst(rst), .req(req_t), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_t), .err(err_t), .rdata(rdata_t), .pin_out(pout_t), .ale(ale_t),
        .slice_idx(sidx_t), .rd_n(rdn_t), .wr_n(wrn_t), .pin_io_in(pin_io_in),
        .pin_io_out(pio_t), .pin_io_oe(oe_t), .ext_wait(ext_wait)
    );

    r2a03_ext_bus_mux #(.ADDR_W(12), .PIN_W(4), .DATA_W(8)) u_o (
        .clk(clk), .rst(rst), .req(req_o), .we(we), .addr(addr[11:0]), .wdata(wdata),
        .ack(ack_o), .err(err_o), .rdata(rdata_o), .pin_out(pout_o), .ale(ale_o),
        .slice_idx(sidx_o), .rd_n(rdn_o), .wr_n(wrn_o), .pin_io_in(pin_io_in[3:0]),
        .pin_io_out(pio_o), .pin_io_oe(oe_o), .ext_wait(ext_wait)
    );

    function automatic obs_t obs(input int s);
        obs_t o;
        case (s)
            0: o = {ack_a, err_a, rdata_a, pout_a, ale_a, sidx_a, rdn_a, wrn_a, pio_a, oe_a};
            1: o = {ack_t, err_t, rdata_t, pout_t, ale_t, sidx_t, rdn_t, wrn_t, pio_t, oe_t};
            default: o = {ack_o, err_o, rdata_o, 4'h0, pout_o, ale_o, sidx_o, rdn_o, wrn_o,
                          4'h0, pio_o, 4'h0, oe_o};
        endcase
        return o;
    endfunction

    task automatic set_req(input int s, input logic v);
        case (s)
            0: req_a = v;
            1: req_t = v;
            default: req_o = v;
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transaction: push the expected completion, drive the request,
    // record a per-cycle trace (tr[k] = k cycles after the accept cycle),
    // feed read slices / wait states during DATA, then pop and compare at ack.
    // nwait < 0 holds ext_wait high for the whole transaction.
    task automatic run_txn(input int s, input logic w, input logic [15:0] a,
                           input logic [7:0] wd, input int nwait, input logic keep,
                           input int exp_lat, input logic exp_err,
                           input logic [7:0] exp_rd, input logic chk_rd,
                           input string tag);
        sb_t  e;
        obs_t o;
        int   k;
        int   waits_left;
        bit   done;
        sb.push_back('{exp_err, exp_rd, chk_rd, exp_lat});
        we = w; addr = a; wdata = wd;
        waits_left = nwait;
        ext_wait = (nwait < 0);
        set_req(s, 1'b1);
        rdlow = 0; wrlow = 0; oe_or = '0;
        done = 1'b0;
        k = 1;
        while (k <= 40 && !done) begin
            @(negedge clk);
            o = obs(s);
            tr[k] = o;
            if (!o.rd_n) rdlow++;
            if (!o.wr_n) wrlow++;
            if (!w) oe_or = oe_or | o.oe;
            if (!o.rd_n || !o.wr_n) begin
                pin_io_in = rseq[o.sidx[1:0]];
                if (nwait >= 0) begin
                    ext_wait = (waits_left > 0);
                    if (waits_left > 0) waits_left--;
                end
            end
            if (o.ack) begin
                done = 1'b1;
                e = sb.pop_front();
                check({tag, "_lat"}, 64'(k), 64'(e.lat));
                check({tag, "_err"}, o.err, e.err);
                if (e.chk_rd) check({tag, "_rdata"}, o.rdata, e.rd);
                if (!keep) set_req(s, 1'b0);
                ext_wait = 1'b0;
            end
            k++;
        end
        if (!done) begin
            check({tag, "_ack_timeout"}, 1'b0, 1'b1);
            set_req(s, 1'b0);
            ext_wait = 1'b0;
            if (sb.size() > 0) e = sb.pop_front();
        end
    endtask

    initial begin : stim
        obs_t o;
        logic acks;
        rst_obs = {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 8'h00};
        rseq[0] = 8'h00; rseq[1] = 8'h00; rseq[2] = 8'h00; rseq[3] = 8'h00;

        repeat (2) @(negedge clk);
        check("reset_a", obs(0), rst_obs);
        check("reset_t", obs(1), rst_obs);
        check("reset_o", obs(2), rst_obs);
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, 1'b1, 16'h4015, 8'h0F, 0, 1'b0, 5, 1'b0, 8'h00, 1'b0, "wr");
        check("wr_addr0", {tr[1].ale, tr[1].sidx, tr[1].pin_out}, {1'b1, 4'h0, 8'h15});
        check("wr_addr1", {tr[2].ale, tr[2].sidx, tr[2].pin_out}, {1'b1, 4'h1, 8'h40});
        check("wr_turn", {tr[3].ale, tr[3].oe, tr[3].rd_n, tr[3].wr_n}, {1'b0, 8'h00, 1'b1, 1'b1});
        check("wr_data", {tr[4].pio, tr[4].oe, tr[4].wr_n}, {8'h0F, 8'hFF, 1'b0});
        check("wr_strobe_cycles", 64'(wrlow), 64'd1);
        @(negedge clk);

        rseq[0] = 8'h34;
        run_txn(0, 1'b0, 16'hFFFC, 8'h00, 0, 1'b0, 5, 1'b0, 8'h34, 1'b1, "rd");
        check("rd_addr", {tr[1].pin_out, tr[2].pin_out}, {8'hFC, 8'hFF});
        check("rd_strobe_cycles", 64'(rdlow), 64'd1);
        check("rd_oe_never", oe_or, 8'h00);
        repeat (2) @(negedge clk);
        check("rd_hold", rdata_a, 8'h34);

        rseq[0] = 8'h5A;
        run_txn(0, 1'b0, 16'h1234, 8'h00, 3, 1'b0, 8, 1'b0, 8'h5A, 1'b1, "wait");
        check("wait_strobe_cycles", 64'(rdlow), 64'd4);
        @(negedge clk);

        rseq[0] = 8'h77;
        run_txn(1, 1'b0, 16'h2000, 8'h00, 0, 1'b0, 5, 1'b0, 8'h77, 1'b1, "t_pre");
        @(negedge clk);
        run_txn(1, 1'b0, 16'h2001, 8'h00, -1, 1'b1, 9, 1'b1, 8'h00, 1'b1, "tmo");
        check("tmo_strobe_cycles", 64'(rdlow), 64'd5);
        rseq[0] = 8'h99;
        run_txn(1, 1'b0, 16'h2002, 8'h00, 0, 1'b0, 6, 1'b0, 8'h99, 1'b1, "tmo_next");
        check("tmo_next_idle_gap", {tr[1].ale, tr[2].ale}, {1'b0, 1'b1});
        @(negedge clk);

        rseq[0] = 8'h05; rseq[1] = 8'h0A;
        run_txn(2, 1'b0, 16'h0123, 8'h00, 0, 1'b0, 7, 1'b0, 8'hA5, 1'b1, "odd");
        check("odd_slices", {tr[1].pin_out, tr[2].pin_out, tr[3].pin_out},
              {8'h03, 8'h02, 8'h01});
        check("odd_sidx", {tr[1].sidx, tr[2].sidx, tr[3].sidx}, {4'h0, 4'h1, 4'h2});
        check("odd_data_sidx", {tr[5].sidx, tr[6].sidx, tr[5].rd_n, tr[6].rd_n},
              {4'h0, 4'h1, 1'b0, 1'b0});
        @(negedge clk);

        we = 1'b0; addr = 16'hABCD; req_a = 1'b1;
        @(negedge clk);
        o = obs(0);
        check("mid_addr0", {o.ale, o.sidx, o.pin_out}, {1'b1, 4'h0, 8'hCD});
        @(negedge clk);
        o = obs(0);
        check("mid_addr1", {o.ale, o.sidx, o.pin_out}, {1'b1, 4'h1, 8'hAB});
        rst = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        o = obs(0);
        check("mid_reset", o, {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 8'h00, 8'h00});
        rst = 1'b0;
        acks = 1'b0;
        repeat (8) begin
            @(negedge clk);
            acks = acks | ack_a;
        end
        check("mid_no_ack", acks, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
